conv_window_gen: RTL and testbench
==================================

// Module: conv_window_gen
// PURPOSE
//  - Consumes the raw 8-bit pixel stream (in_val/data_in, raster order, 28x28 frame) entering CNN.
//  - Builds a sliding 3x3 neighbourhood from two line buffers plus a 3x3 window register.
//  - Emits one window per valid ("no padding") position, i.e. 26x26 = 676 windows per frame.
//  - Feeds the first convolution layer's MAC array directly.
// PARAMETERS
//  IMG_W   28  pixels per row (>= 3)
//  IMG_H   28  rows per frame (>= 3)
//  PIX_W   8   bits per pixel
// PORTS
//  clk         in   1         rising-edge clock
//  rst_n       in   1         reset, synchronous, active-low
//  in_val      in   1         data_in holds a valid pixel this cycle; no backpressure
//  data_in     in   PIX_W     pixel, raster order (row-major, col 0 first)
//  win_val     out  1         win_data valid, single-cycle pulse
//  win_data    out  9*PIX_W   element i at [PIX_W*(i+1)-1 : PIX_W*i]; i=0 top-left .. i=8 bottom-right, row-major
//  frame_done  out  1         pulses together with the final window (25,25) of a frame
//  win_row     out  5         [WIN_COORD_EN only] window top-left row, 0..IMG_H-3
//  win_col     out  5         [WIN_COORD_EN only] window top-left col, 0..IMG_W-3
// BEHAVIOUR
//  - Reset (rst_n==0 at a clk edge): col_cnt=0, row_cnt=0, win_val=0, frame_done=0, win_data=0, coords=0.
//    Line-buffer RAM is not cleared; stale contents are never exposed because of row/col gating.
//  - Pixel acceptance: every cycle with in_val=1. When in_val=0, no state changes; win_val and frame_done drop to 0.
//  - Accepted pixel (r,c):
//    - lb1 pushes data_in; lb2 pushes lb1's output (each is a one-row delay of IMG_W entries).
//    - Window shifts left one column; the new right column is {lb2_out, lb1_out, data_in} (top to bottom).
//  - Output: win_val=1 on the cycle after accepting (r,c) iff r>=2 && c>=2. Latency is 1 clk.
//    That window covers rows r-2..r and cols c-2..c; win_row=r-2, win_col=c-2.
//  - Row wrap: at c==IMG_W-1, col_cnt->0 and row_cnt++.
//    The window register is not flushed; the gate c>=2 suppresses the two straddling positions.
//  - Frame wrap: at (IMG_H-1, IMG_W-1), both counters return to 0 and frame_done pulses with that window.
//    The next frame may start on the very next cycle (no bubble required).
//  - Counter widths: $clog2(IMG_W) and $clog2(IMG_H); counters never exceed IMG_W-1 / IMG_H-1.
//  - Reset mid-frame: takes effect at that edge. The next accepted pixel is treated as (0,0) of a new frame,
//    and no window from the aborted frame is ever emitted.
//  - Simultaneous rst_n=0 and in_val=1: reset wins and the pixel is dropped.
// CONFIGURATION
//  - WIN_COORD_EN defined: win_row/win_col ports exist and are registered alongside win_data.
//  - WIN_COORD_EN undefined: both ports and their registers are absent; all other behaviour is identical.
// STRUCTURE
//  - cnn_pkg: IMG_W, IMG_H, PIX_W, KSZ=3 constants; pix_t typedef; win_t (array of 9 pix_t).
//  - Sub-module line_buffer (params DEPTH, WIDTH; ports clk, en, din, dout):
//    circular RAM with a wrapping pointer, pure one-row delay, no reset on storage. Instantiated twice (lb1, lb2).
// TESTING
//  1. Ramp frame, pixel = (r*28+c)&0xFF, in_val held 1 -> exactly 676 win_val pulses.
//     First pulse follows acceptance of pixel index 58, with win_data = {58,57,56,30,29,28,2,1,0} (i=8..0).
//  2. Row boundary: accepting pixels (3,0) and (3,1) -> win_val=0. Accepting (3,2) -> window {86,85,84,58,57,56,30,29,28}.
//  3. Same ramp with in_val random (~40% duty) -> identical window sequence to test 1.
//     win_val is high only on the cycle after an accepted pixel.
//  4. Two back-to-back frames (second frame = ramp+100) -> frame_done exactly once per frame, on window (25,25).
//     First window of frame 2 = frame-2 values only, with no frame-1 pixels.
//  5. rst_n low for 1 cycle after pixel 400 -> win_val=0 next cycle. A fresh frame afterwards yields its
//     first window after pixel 58 and a total of 676.
//  6. WIN_COORD_EN build, test 1 stimulus -> (win_row,win_col) steps (0,0)..(0,25),(1,0)..(25,25) in order.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and pixel/window types for the CNN front end.
package cnn_pkg;

  localparam int IMG_W = 28;
  localparam int IMG_H = 28;
  localparam int PIX_W = 8;
  localparam int KSZ   = 3;
  localparam int WIN_N = KSZ * KSZ;

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);

  typedef logic [PIX_W-1:0] pix_t;
  // Packed so element i lands at bits [PIX_W*(i+1)-1 : PIX_W*i].
  typedef pix_t [WIN_N-1:0] win_t;

endpackage

// File: rtl/line_buffer.sv
// One-row delay line: circular RAM with a wrapping pointer, storage is never reset.
module line_buffer #(
  parameter int DEPTH = 28,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] ptr_d;

  // The slot about to be overwritten holds the sample pushed DEPTH accepts ago.
  assign dout = mem_q[ptr_q];

  always_comb begin
    ptr_d = ptr_q;
    if (en) begin
      if (ptr_q == PTR_W'(DEPTH - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = ptr_q + PTR_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[ptr_q] <= din;
    end
    ptr_q <= ptr_d;
  end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding 3x3 window generator over a raster pixel stream (valid positions only).
// Optional WIN_COORD_EN adds registered win_row/win_col outputs.
module conv_window_gen
  import cnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_val,
  input  logic [PIX_W-1:0]       data_in,
  output logic                   win_val,
  output logic [WIN_N*PIX_W-1:0] win_data,
  output logic                   frame_done
`ifdef WIN_COORD_EN
  ,
  output logic [ROW_W-1:0]       win_row,
  output logic [COL_W-1:0]       win_col
`endif
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  win_t             win_q, win_d;
  logic             win_val_q, win_val_d;
  logic             frame_done_q, frame_done_d;
  pix_t             lb1_out, lb2_out;
  logic             accept;
  logic             last_col, last_row, win_ok;

  // A pixel arriving with reset asserted is dropped, including from the line buffers.
  assign accept   = in_val & rst_n;
  assign last_col = (col_q == COL_W'(IMG_W - 1));
  assign last_row = (row_q == ROW_W'(IMG_H - 1));
  assign win_ok   = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) lb1 (
    .clk  (clk),
    .en   (accept),
    .din  (data_in),
    .dout (lb1_out)
  );

  line_buffer #(.DEPTH(IMG_W), .WIDTH(PIX_W)) lb2 (
    .clk  (clk),
    .en   (accept),
    .din  (lb1_out),
    .dout (lb2_out)
  );

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    win_val_d    = 1'b0;
    frame_done_d = 1'b0;
    if (in_val) begin
      for (int k = 0; k < KSZ; k++) begin
        win_d[KSZ*k]     = win_q[KSZ*k + 1];
        win_d[KSZ*k + 1] = win_q[KSZ*k + 2];
      end
      win_d[2] = lb2_out;
      win_d[5] = lb1_out;
      win_d[8] = data_in;
      // Straddling positions after a row wrap are hidden by the column gate.
      win_val_d    = win_ok;
      frame_done_d = last_col && last_row;
      if (last_col) begin
        col_d = '0;
        if (last_row) begin
          row_d = '0;
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
        row_d = row_q;
      end
    end else begin
      win_val_d    = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '0;
      win_val_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      win_val_q    <= win_val_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_val    = win_val_q;
  assign win_data   = win_q;
  assign frame_done = frame_done_q;

`ifdef WIN_COORD_EN
  logic [ROW_W-1:0] win_row_q, win_row_d;
  logic [COL_W-1:0] win_col_q, win_col_d;

  always_comb begin
    win_row_d = win_row_q;
    win_col_d = win_col_q;
    if (in_val && win_ok) begin
      win_row_d = row_q - ROW_W'(2);
      win_col_d = col_q - COL_W'(2);
    end else begin
      win_row_d = win_row_q;
      win_col_d = win_col_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      win_row_q <= '0;
      win_col_q <= '0;
    end else begin
      win_row_q <= win_row_d;
      win_col_q <= win_col_d;
    end
  end

  assign win_row = win_row_q;
  assign win_col = win_col_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen: image-array reference model, directed + randomized frames.
module tb_conv_window_gen;
  import cnn_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_val;
  logic [7:0]  data_in;
  logic        win_val;
  logic [71:0] win_data;
  logic        frame_done;
`ifdef WIN_COORD_EN
  logic [4:0]  win_row;
  logic [4:0]  win_col;
`endif

  always #5 clk = ~clk;

  conv_window_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_val     (in_val),
    .data_in    (data_in),
    .win_val    (win_val),
    .win_data   (win_data),
    .frame_done (frame_done)
`ifdef WIN_COORD_EN
    ,
    .win_row    (win_row),
    .win_col    (win_col)
`endif
  );

  int tests = 0;
  int fails = 0;

  byte unsigned img [28][28];
  int mr = 0;
  int mc = 0;
  int obs_win = 0;
  int obs_fd  = 0;
  logic [71:0] first_win;
  logic [71:0] row3_win;
  logic [71:0] first_exp;
  logic [71:0] row3_exp;

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, advance the model, check outputs 1 time unit after the edge.
  task automatic step(input bit rst, input bit v, input logic [7:0] p);
    logic        exp_v;
    logic        exp_fd;
    logic [71:0] exp_w;
    int r;
    int c;
    rst_n   = !rst;
    in_val  = v;
    data_in = p;
    @(posedge clk);
    exp_v  = 1'b0;
    exp_fd = 1'b0;
    exp_w  = '0;
    r = -1;
    c = -1;
    if (rst) begin
      mr = 0;
      mc = 0;
    end else if (v) begin
      r = mr;
      c = mc;
      img[r][c] = p;
      if (r >= 2 && c >= 2) begin
        exp_v = 1'b1;
        for (int i = 0; i < 9; i++) exp_w[8*i +: 8] = img[r-2+i/3][c-2+i%3];
      end
      exp_fd = (r == 27 && c == 27);
      mc++;
      if (mc == 28) begin
        mc = 0;
        mr = (mr == 27) ? 0 : mr + 1;
      end
    end
    #1;
    chk("win_val", win_val, exp_v);
    chk("frame_done", frame_done, exp_fd);
    if (win_val === 1'b1) obs_win++;
    if (frame_done === 1'b1) obs_fd++;
    if (rst) begin
      chk("win_data_reset", win_data, 72'd0);
`ifdef WIN_COORD_EN
      chk("win_row_reset", win_row, 72'd0);
      chk("win_col_reset", win_col, 72'd0);
`endif
    end
    if (exp_v) begin
      chk("win_data", win_data, exp_w);
`ifdef WIN_COORD_EN
      chk("win_row", win_row, 72'(r - 2));
      chk("win_col", win_col, 72'(c - 2));
`endif
    end
    if (r == 2 && c == 2) first_win = win_data;
    if (r == 3 && c == 2) row3_win = win_data;
  endtask

  // Feed n_pix accepted pixels; idle cycles are inserted at ~60% when rnd_valid.
  task automatic feed(input int off, input bit rnd_valid, input bit rnd_pix, input int n_pix);
    int k = 0;
    logic [7:0] px;
    while (k < n_pix) begin
      if (rnd_valid && $urandom_range(0, 99) >= 40) begin
        step(1'b0, 1'b0, 8'($urandom));
      end else begin
        px = rnd_pix ? 8'($urandom) : 8'((k + off) & 255);
        step(1'b0, 1'b1, px);
        k++;
      end
    end
  endtask

  task automatic frame_counts(input string tag);
    chk({tag, "_win_count"}, 72'(obs_win), 72'd676);
    chk({tag, "_fd_count"}, 72'(obs_fd), 72'd1);
    obs_win = 0;
    obs_fd  = 0;
  endtask

  initial begin
    byte unsigned fe [9] = '{8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58};
    byte unsigned re [9] = '{8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58, 8'd84, 8'd85, 8'd86};
    for (int i = 0; i < 9; i++) begin
      first_exp[8*i +: 8] = fe[i];
      row3_exp[8*i +: 8]  = re[i];
    end
    rst_n   = 1'b0;
    in_val  = 1'b0;
    data_in = 8'd0;

    // Reset state
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    obs_win = 0;
    obs_fd  = 0;

    // Ramp frame, continuous valid; first window and row-boundary window
    feed(0, 1'b0, 1'b0, 784);
    frame_counts("ramp");
    chk("first_window", first_win, first_exp);
    chk("row3_col2_window", row3_win, row3_exp);

    // Same ramp with sparse valid
    feed(0, 1'b1, 1'b0, 784);
    frame_counts("ramp_sparse");
    chk("sparse_first_window", first_win, first_exp);

    // Back-to-back: ramp then ramp+100
    feed(0, 1'b0, 1'b0, 784);
    frame_counts("b2b_f1");
    feed(100, 1'b0, 1'b0, 784);
    frame_counts("b2b_f2");
    for (int i = 0; i < 9; i++) first_exp[8*i +: 8] = 8'(fe[i] + 100);
    chk("b2b_f2_first_window", first_win, first_exp);
    for (int i = 0; i < 9; i++) first_exp[8*i +: 8] = fe[i];

    // Random pixel data with sparse valid
    feed(0, 1'b1, 1'b1, 784);
    frame_counts("random");

    // Reset mid-frame after pixel 400 with in_val high; pixel is dropped
    feed(0, 1'b0, 1'b0, 401);
    step(1'b1, 1'b1, 8'hAA);
    obs_win = 0;
    obs_fd  = 0;
    first_win = '0;
    feed(0, 1'b0, 1'b0, 784);
    frame_counts("after_reset");
    chk("after_reset_first_window", first_win, first_exp);

    step(1'b0, 1'b0, 8'd0);
    step(1'b0, 1'b0, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
